// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply (shift-add) and restoring divide, {hi,lo} result
module muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_nx, fix_val, dz_val;
    logic [WIDTH-1:0] b_abs, abs1, abs2, mh, ml;
    logic [WIDTH:0] ms, shifted;
    logic is_div, neg_q, neg_r, s1, s2, accept, sub_ok, in_flight, dz;
    always_comb begin
        s1 = ~op[0] & operand1[WIDTH-1];
        s2 = ~op[0] & operand2[WIDTH-1];
        abs1 = s1 ? -operand1 : operand1;
        abs2 = s2 ? -operand2 : operand2;
        accept = state == IDLE && start && !cancel;
        in_flight = state == MUL || state == DIV || state == FIX;
        dz = state == DIV && b_abs == '0;
        mh = acc[2*WIDTH-1:WIDTH];
        ml = acc[WIDTH-1:0];
        ms = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            ms = {1'b0, mh} + (ml[0] ? {1'b0, b_abs} : '0);
            ml = {ms[0], ml[WIDTH-1:1]};
            mh = ms[WIDTH:1];
        end
        // restoring step: partial remainder is {hi, next dividend bit}
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        sub_ok = shifted >= {1'b0, b_abs};
        acc_nx = state == MUL ? {mh, ml}
               : state == DIV ? {sub_ok ? shifted[WIDTH-1:0] - b_abs : shifted[WIDTH-1:0], acc[WIDTH-2:0], sub_ok}
               : acc;
        fix_val = !is_div ? (neg_q ? -acc : acc)
                : {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH], neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]};
        dz_val = {neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0], {WIDTH{1'b1}}};
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (op[1] ? DIV : MUL) : IDLE;
            MUL:     state_nx = cnt == '0 ? FIX : MUL;
            DIV:     state_nx = dz ? DONE : (cnt == '0 ? FIX : DIV);
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (cancel && in_flight) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            acc         <= '0;
            b_abs       <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state_nx == MUL || state_nx == DIV || state_nx == FIX;
            done  <= state_nx == DONE;
            acc   <= acc_nx;
            if (accept) begin
                acc         <= {{WIDTH{1'b0}}, op[1] ? abs1 : abs2};
                b_abs       <= op[1] ? abs2 : abs1;
                cnt         <= op[1] ? CW'(WIDTH - 1) : CW'(WIDTH / MUL_STEP - 1);
                is_div      <= op[1];
                neg_q       <= s1 ^ s2;
                neg_r       <= s1;
                div_by_zero <= 1'b0;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt - CW'(1);
            end
            if (state == FIX && !cancel) result <= fix_val;
            if (dz && !cancel) begin
                result      <= dz_val;
                div_by_zero <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vectors; expectations queued at issue, checked by a done-driven monitor
module tb_muldiv_iter;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, start1 = 1'b0, cancel = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] operand1 = '0, operand2 = '0;
    logic busy, done, div_by_zero, busy1, done1, dbz1;
    logic [63:0] result, result1;
    int cyc = 0, n_chk = 0, n_fail = 0;
    typedef struct {logic [63:0] res; logic dbz; int at;} exp_t;
    exp_t q[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter #(.WIDTH(32), .MUL_STEP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .operand1(operand1), .operand2(operand2),
        .cancel(cancel), .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
    );
    muldiv_iter #(.WIDTH(32), .MUL_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .operand1(operand1), .operand2(operand2),
        .cancel(1'b0), .busy(busy1), .done(done1), .result(result1), .div_by_zero(dbz1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL u0_done: unexpected done got 1 want 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("u0_result", result, e.res);
                chk("u0_div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                chk("u0_done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL u1_done: unexpected done got 1 want 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1_result", result1, e.res);
                chk("u1_done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic wait_done(input bit which);
        int k = 0;
        while ((which ? done1 : done) !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk(which ? "u1_done_seen" : "u0_done_seen", 64'(which ? done1 : done), 64'd1);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] r, input logic z, input int lat);
        op = o;
        operand1 = a;
        operand2 = b;
        start = 1'b1;
        q.push_back('{r, z, cyc + lat});
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        // MULT with start held through busy and DONE; operands scrambled after capture
        op = 2'b00;
        operand1 = 32'hFFFFFFFD;
        operand2 = 32'h00000007;
        start = 1'b1;
        q.push_back('{64'hFFFFFFFF_FFFFFFEB, 1'b0, cyc + 18});
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) begin
                op = 2'b11;
                operand1 = 32'h12345678;
                operand2 = 32'h0;
            end
            chk($sformatf("mult_busy_c%0d", k), 64'(busy), 64'(k <= 17));
        end
        @(negedge clk);
        start = 1'b0;
        // MULTU on both radix configurations
        op = 2'b01;
        operand1 = 32'hFFFFFFFF;
        operand2 = 32'hFFFFFFFF;
        start = 1'b1;
        start1 = 1'b1;
        q.push_back('{64'hFFFFFFFE_00000001, 1'b0, cyc + 18});
        q1.push_back('{64'hFFFFFFFE_00000001, 1'b0, cyc + 34});
        @(negedge clk);
        start = 1'b0;
        start1 = 1'b0;
        wait_done(1'b0);
        wait_done(1'b1);
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34);
        issue(2'b10, 32'h00000064, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0, 34);
        issue(2'b10, 32'hFFFFFF9C, 32'h00000007, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 34);
        issue(2'b11, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 1'b0, 34);
        issue(2'b00, 32'hFFFFFFF0, 32'hFFFFFFF0, 64'h00000000_00000100, 1'b0, 18);
        issue(2'b00, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0, 18);
        issue(2'b10, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 2);
        issue(2'b11, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 1'b1, 2);
        chk("dbz_held", 64'(div_by_zero), 64'd1);
        issue(2'b11, 32'h00000009, 32'h00000004, 64'h00000001_00000002, 1'b0, 34);
        // DIV cancelled in cycle 5, then a fresh start in cycle 7
        op = 2'b10;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("cancel_busy_c5", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_c6", 64'(busy), 64'd0);
        chk("cancel_result_held", result, 64'h00000001_00000002);
        chk("cancel_dbz_held", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        issue(2'b01, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 1'b0, 18);
        // start with cancel in IDLE is dropped
        op = 2'b00;
        operand1 = 32'd5;
        operand2 = 32'd5;
        start = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        chk("start_cancel_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("start_cancel_busy_later", 64'(busy), 64'd0);
        // reset in the middle of a MULT
        op = 2'b00;
        operand1 = 32'd3;
        operand2 = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid_busy_c9", 64'(busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        issue(2'b11, 32'h00000009, 32'h00000004, 64'h00000001_00000002, 1'b0, 34);
        repeat (40) @(negedge clk);
        chk("u0_queue_drained", 64'(q.size()), 64'd0);
        chk("u1_queue_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
